// File: rtl/dmem_responder.sv
// Single-port data memory responder with a fixed response latency.
// Optional per-byte write masking is enabled by defining DMEM_BYTE_EN.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for req; request inputs sampled here only
  // WAIT  | counting down the configured latency
  // RESP  | ack high for one cycle with rdata/err valid
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        accept;
  logic        enter_resp;

  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_we;
  logic [3:0]  acc_be;
  logic        acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic        do_write;

  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [WORDS];

`ifdef DMEM_BYTE_EN
  logic [3:0] be_q;
`else
  logic unused_be;
  assign unused_be = &{1'b0, be};
`endif

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the access happens on the accepting edge, so it must
  // use the live inputs instead of the latched copies.
  always_comb begin
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_we    = we_q;
`ifdef DMEM_BYTE_EN
    acc_be    = be_q;
`else
    acc_be    = 4'hF;
`endif
    if (state_q == IDLE) begin
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_we    = we;
`ifdef DMEM_BYTE_EN
      acc_be    = be;
`endif
    end
  end

  assign acc_err  = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign acc_idx  = acc_addr[DEPTH_LOG2+1:2];
  assign do_write = rst & enter_resp & acc_we & ~acc_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
`ifdef DMEM_BYTE_EN
      be_q    <= 4'd0;
`endif
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= we;
`ifdef DMEM_BYTE_EN
        be_q    <= be;
`endif
        cnt_q   <= LAT;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_resp) begin
        rdata_q <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
        err_q   <= acc_err;
      end else begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign ack   = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/back-to-back corner
// sequences and randomized traffic against a word-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = 4'hF;
  logic        ack, err, busy;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  be0 = 4'hF;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0), .be(be0),
    .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];
  logic [31:0] model[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance; inputs are scrambled while busy.
  task automatic txn(input bit skip_sync, input logic t_we, input logic [31:0] t_addr,
                     input logic [31:0] t_wdata, input logic [3:0] t_be,
                     output logic [31:0] o_rdata, output logic o_err,
                     output int o_lat, output logic o_quiet);
    if (!skip_sync) @(negedge clk);
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
    @(posedge clk);
    #1;
    req = 1'($urandom_range(0, 1)); we = 1'($urandom); addr = $urandom;
    wdata = $urandom; be = 4'($urandom);
    o_lat = 0; o_quiet = 1'b1; o_rdata = '0; o_err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        o_lat = n; o_rdata = rdata; o_err = err;
        break;
      end
      if (rdata !== 32'd0 || err !== 1'b0 || busy !== 1'b1) o_quiet = 1'b0;
    end
    req = 1'b0;
  endtask

  task automatic run_check(input string name, input bit skip_sync, input logic t_we,
                           input logic [31:0] t_addr, input logic [31:0] t_wdata,
                           input logic [3:0] t_be, input logic [31:0] e_rdata,
                           input logic e_err);
    logic [31:0] r;
    logic        e, q;
    int          lat;
    txn(skip_sync, t_we, t_addr, t_wdata, t_be, r, e, lat, q);
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_err"}, {31'd0, e}, {31'd0, e_err});
    check({name, "_rdata"}, r, e_rdata);
    check({name, "_quiet_busy"}, {31'd0, q}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, wd, exp_r;
    logic [3:0]  b;
    logic        w, exp_e;
    int          acks;

    vecs[0]  = '{1'b1, 32'h0000_00A0, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_00A0, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0002, 32'h0,         4'hF, 32'h0, 1'b1};
    vecs[4]  = '{1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 4'hF, 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h1234_5678, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0};
`ifdef DMEM_BYTE_EN
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
`else
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hAABB_CCDD, 1'b0};
`endif
    vecs[9]  = '{1'b1, 32'h0000_0014, 32'h0000_0055, 4'hF, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0014, 32'h0000_0066, 4'h0, 32'h0, 1'b0};
`ifdef DMEM_BYTE_EN
    vecs[11] = '{1'b0, 32'h0000_0014, 32'h0,         4'hF, 32'h0000_0055, 1'b0};
`else
    vecs[11] = '{1'b0, 32'h0000_0014, 32'h0,         4'hF, 32'h0000_0066, 1'b0};
`endif
    vecs[12] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0};
    vecs[14] = '{1'b0, 32'h8000_0000, 32'h0,         4'hF, 32'h0, 1'b1};
    vecs[15] = '{1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
    vecs[16] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h1234_5678, 1'b0};
    vecs[17] = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 32'h0, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_flags", {29'd0, ack, busy, err}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_flags0", {29'd0, ack0, busy0, err0}, 32'd0);
    check("reset_rdata0", rdata0, 32'd0);
    rst = 1'b1;

    // Directed table
    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), 1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);

    // Reset mid-WAIT abandons the write; memory keeps its prior value
    run_check("rst_prewrite", 1'b0, 1'b1, 32'h20, 32'h77, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h5; be = 4'hF;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("rst_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_busy_async", {31'd0, busy}, 32'd0);
    check("rst_ack_async", {31'd0, ack}, 32'd0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack !== 1'b0 || busy !== 1'b0) acks++;
    end
    check("rst_held_quiet", 32'(acks), 32'd0);
    rst = 1'b1;
    run_check("rst_resume_read", 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h77, 1'b0);

    // Continuous req on the zero-latency instance
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; be0 = 4'hF; wdata0 = 32'd0;
    acks = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check($sformatf("l0_ack_c%0d", i), {31'd0, ack0}, {31'd0, 1'(i % 2)});
      check($sformatf("l0_busy_c%0d", i), {31'd0, busy0}, {31'd0, 1'(i % 2)});
      if (ack0 === 1'b1) acks++;
      wdata0 = 32'(i);
      if (i == 20) req0 = 1'b0;
    end
    check("l0_ack_count", 32'(acks), 32'd10);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    check("l0_read_ack", {31'd0, ack0}, 32'd1);
    check("l0_read_rdata", rdata0, 32'd18);
    check("l0_read_err", {31'd0, err0}, 32'd0);

    // Randomized traffic against a word-array model covering words 0..31
    for (int i = 0; i < 32; i++) begin
      wd = $urandom;
      model[i] = wd;
      run_check($sformatf("init%0d", i), 1'b0, 1'b1, 32'(i * 4), wd, 4'hF, 32'h0, 1'b0);
    end
    for (int k = 0; k < 150; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 31) * 4);
      if (kind == 8) a = a + 32'($urandom_range(1, 3));
      if (kind == 9) a = 32'h1000 | $urandom;
      w  = 1'($urandom);
      wd = $urandom;
      b  = 4'($urandom);
      exp_e = (a % 4 != 0) || (a >= 32'h1000);
      exp_r = 32'h0;
      if (w) begin
        if (!exp_e) begin
          for (int j = 0; j < 4; j++) begin
`ifdef DMEM_BYTE_EN
            if (b[j]) model[a / 4][8*j +: 8] = wd[8*j +: 8];
`else
            model[a / 4][8*j +: 8] = wd[8*j +: 8];
`endif
          end
        end
      end else if (!exp_e) begin
        exp_r = model[a / 4];
      end
      run_check($sformatf("rnd%0d", k), 1'b0, w, a, wd, b, exp_r, exp_e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, number of wait cycles inserted before response (legal 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  initiator request strobe, sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port be  input  4  byte enables, be[i] selects wdata[8i+7:8i]; ignored unless DMEM_BYTE_EN is defined.
REQ-010 SHALL have port ack  output  1  one-cycle response strobe.
REQ-011 SHALL have port rdata  output  32  read data, valid while ack=1.
REQ-012 SHALL have port err  output  1  error flag, valid while ack=1.
REQ-013 SHALL have port busy  output  1  transaction in flight (WAIT or RESP).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL, in IDLE with req=1 at posedge: latch addr/we/wdata/be, load counter with LATENCY, go to WAIT (LATENCY>0) or RESP (LATENCY=0).
REQ-016 SHALL, in WAIT, decrement counter each cycle and enter RESP on the edge where counter==1.
REQ-017 SHALL perform the memory access on the edge entering RESP: write commits; read result registered into rdata.
REQ-018 SHALL hold ack=1 for exactly the RESP cycle, then return to IDLE; ack asserts LATENCY+1 cycles after the accepting edge.
REQ-019 SHALL ignore req, we, addr, wdata, be while busy=1; earliest next accept is the cycle after ack.
REQ-020 SHALL hold busy=1 in WAIT and RESP, 0 in IDLE.
REQ-021 SHALL flag err=1 with ack when addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0; such writes are suppressed and rdata=0.
REQ-022 SHALL use word index addr[DEPTH_LOG2+1:2]; no wrap-around (out-of-range is error, never aliased).
REQ-023 SHALL return on a read the value from the most recent completed write to that word (no stale data).
REQ-024 SHALL drive rdata=0 and err=0 whenever ack=0.
REQ-025 SHALL accept req asserted continuously as a new request each time IDLE is reached.

Reset
REQ-026 SHALL, on rst=0, asynchronously force state IDLE, counter 0, ack 0, err 0, busy 0, rdata 0.
REQ-027 SHALL abandon an in-flight transaction on reset with no write committed and no ack.
REQ-028 SHALL not clear memory contents on reset.
REQ-029 SHALL resume accepting req on the first posedge after rst returns high.

Configuration
REQ-030 SHALL, with DMEM_BYTE_EN defined, write only bytes whose be bit is 1 (be=0000 writes nothing, still acks, err=0).
REQ-031 SHALL, without DMEM_BYTE_EN, write all 4 bytes regardless of be.

Verification
REQ-032 LATENCY=2: write 0x000000A0<-0xDEADBEEF, then read 0xA0 -> each ack exactly 3 cycles after accept, rdata=0xDEADBEEF, err=0.
REQ-033 Read addr 0x00000002 -> ack with err=1, rdata=0; write to 0x00001000 (DEPTH_LOG2=10) -> err=1, word 0 unchanged.
REQ-034 DMEM_BYTE_EN, word 0x10=0x11223344, write be=0101 wdata=0xAABBCCDD -> read returns 0x11BB33DD; without macro -> 0xAABBCCDD.
REQ-035 Hold req=1 for 20 cycles, LATENCY=0 -> ack every 2nd cycle, busy toggles, requests during busy not counted.
REQ-036 Assert rst=0 mid-WAIT of write 0x20<-0x5 -> ack never asserts, busy=0 immediately, later read 0x20 returns prior value.
